seq_buf_reader: RTL and testbench

- Read-side sequencer for the team's sequential-access capture buffers, i.e. the auto-incrementing write/read RAMs used for line and DMA staging.
- On a start command it issues exactly LEN read strobes to the buffer and captures the returned words into an internal FIFO. It then presents them as a valid/ready stream to the consumer, e.g. a video line fetch or a host readback.
- Read strobes are throttled so the consumer can stall indefinitely without losing any word.

---
 rtl/seq_buf_reader_if.sv | 34 +++
 rtl/seq_buf_reader.sv | 178 +++++++++++++++++
 tb/tb_seq_buf_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_buf_reader_if.sv
// ============================================================================
//  Module   : seq_buf_reader_if
//  Brief    : Command, buffer-read and output-stream signals of seq_buf_reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_buf_reader_if #(
   parameter int DATAWIDTH = 16,
   parameter int LENWIDTH  = 10
);
   logic                 start;
   logic [LENWIDTH-1:0]  len;
   logic                 abort;
   logic                 mem_rd;
   logic [DATAWIDTH-1:0] mem_q;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATAWIDTH-1:0] out_data;
   logic                 busy;
   logic                 done;

   modport slave (
      input  start, len, abort, mem_q, out_ready,
      output mem_rd, out_valid, out_data, busy, done
   );

   modport master (
      output start, len, abort, mem_q, out_ready,
      input  mem_rd, out_valid, out_data, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/seq_buf_reader.sv
// ============================================================================
//  Module   : seq_buf_reader
//  Brief    : Issues LEN read strobes to a sequential buffer and streams the
//             returned words out through a small credit-protected FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_buf_reader #(
   parameter int DATAWIDTH  = 16,
   parameter int LENWIDTH   = 10,
   parameter int FIFO_DEPTH = 4
) (
   input wire logic        clock,
   input wire logic        reset,
   seq_buf_reader_if.slave bus
);

   localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [LENWIDTH-1:0]  r_len_q;
   logic [LENWIDTH-1:0]  r_issued;
   logic [LENWIDTH-1:0]  r_accepted;
   logic                 r_mem_rd;
   logic                 r_rd_d1;
   logic                 r_busy;
   logic                 r_done;

   logic [DATAWIDTH-1:0] r_fifo [FIFO_DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;

   logic                 w_abort;
   logic                 w_start_ok;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_credit;
   logic                 w_rd_next;
   logic [c_CNT_W:0]     w_committed;

   // Every word already owed to the FIFO (stored, strobing now, or returning
   // now) plus the one about to be requested must fit.
   assign w_committed = {1'b0, r_count}
                      + {{c_CNT_W{1'b0}}, r_mem_rd}
                      + {{c_CNT_W{1'b0}}, r_rd_d1}
                      + (c_CNT_W+1)'(1);
   assign w_credit    = (w_committed <= {1'b0, c_DEPTH});

   assign w_abort = bus.abort && (r_state != ST_IDLE);
   assign w_push  = r_rd_d1;
   assign w_pop   = (r_count != '0) && bus.out_ready;

   always_comb begin
      w_state_next = r_state;
      w_rd_next    = 1'b0;
      w_start_ok   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               w_start_ok = 1'b1;
               if (bus.len != '0) begin
                  w_state_next = ST_RUN;
                  w_rd_next    = 1'b1;
               end else begin
                  w_state_next = ST_FINISH;
               end
            end
         end
         ST_RUN: begin
            if (r_accepted == r_len_q) begin
               w_state_next = ST_FINISH;
            end else begin
               w_rd_next = (r_issued < r_len_q) && w_credit;
            end
         end
         ST_FINISH: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      if (w_abort) begin
         w_state_next = ST_IDLE;
         w_rd_next    = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_len_q    <= '0;
         r_issued   <= '0;
         r_accepted <= '0;
         r_mem_rd   <= 1'b0;
         r_rd_d1    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_mem_rd <= w_rd_next;
         r_rd_d1  <= w_abort ? 1'b0 : r_mem_rd;
         r_busy   <= (w_state_next == ST_RUN);
         r_done   <= (w_state_next == ST_FINISH);
         if (w_start_ok) begin
            r_len_q    <= bus.len;
            r_issued   <= LENWIDTH'(w_rd_next);
            r_accepted <= '0;
         end else begin
            if (w_rd_next) begin
               r_issued <= r_issued + 1'b1;
            end
            if (w_pop && !w_abort && (r_state == ST_RUN)) begin
               r_accepted <= r_accepted + 1'b1;
            end
         end
      end
   end

   // Data returning for a strobe issued before an abort is dropped here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo[i] <= '0;
         end
      end else if (w_push && !w_abort) begin
         r_fifo[r_wr_ptr] <= bus.mem_q;
      end
   end

   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      !(w_push && !w_pop && !w_abort && (r_count == c_DEPTH)));

   assign bus.mem_rd    = r_mem_rd;
   assign bus.out_valid = (r_count != '0);
   assign bus.out_data  = r_fifo[r_rd_ptr];
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_buf_reader.sv
// ============================================================================
//  Module   : tb_seq_buf_reader
//  Brief    : Directed self-checking bench for seq_buf_reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_buf_reader;

   localparam int DW    = 16;
   localparam int LW    = 10;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   seq_buf_reader_if #(.DATAWIDTH(DW), .LENWIDTH(LW)) bus ();

   seq_buf_reader #(
      .DATAWIDTH  (DW),
      .LENWIDTH   (LW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [DW-1:0] word(input int i);
      return DW'(i * 7 + 32'h1234);
   endfunction

   // Buffer model: one-cycle read latency, auto-incrementing pointer.
   int buf_ptr;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         buf_ptr   <= 0;
         bus.mem_q <= '0;
      end else if (bus.mem_rd) begin
         bus.mem_q <= word(buf_ptr);
         buf_ptr   <= buf_ptr + 1;
      end
   end

   int rd_cnt   = 0;
   int done_cnt = 0;
   int max_cnt  = 0;
   logic [DW-1:0] got [$];

   always @(negedge clock) begin
      if (!reset) begin
         if (bus.mem_rd) rd_cnt++;
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
         if (bus.done) done_cnt++;
         if (int'(dut.r_count) > max_cnt) max_cnt = int'(dut.r_count);
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic record(input int n, output logic [31:0] rd_m, output logic [31:0] vld_m,
                         output logic [31:0] done_m, output logic [31:0] busy_m);
      rd_m = '0; vld_m = '0; done_m = '0; busy_m = '0;
      for (int c = 0; c < n; c++) begin
         tick();
         bus.start = 1'b0;
         rd_m[c]   = bus.mem_rd;
         vld_m[c]  = bus.out_valid;
         done_m[c] = bus.done;
         busy_m[c] = bus.busy;
      end
   endtask

   task automatic wait_done(input int limit, input string tag);
      int n = 0;
      while (bus.done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
      tick();
   endtask

   function automatic int data_errs(input int base, input int first_word, input int n);
      int e = 0;
      for (int k = 0; k < n; k++) begin
         if (base + k >= got.size()) e++;
         else if (got[base + k] !== word(first_word + k)) e++;
      end
      return e;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd_m, vld_m, done_m, busy_m;
      logic [DW-1:0] snap;
      int rd0, g0, d0, g1, n;

      bus.start     = 1'b0;
      bus.len       = '0;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_mem_rd",    32'(bus.mem_rd),    32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_done",      32'(bus.done),      32'd0);

      // Basic burst, len=8, always ready
      rd0 = rd_cnt; g0 = got.size(); d0 = done_cnt;
      bus.out_ready = 1'b1;
      bus.len       = LW'(8);
      bus.start     = 1'b1;
      record(14, rd_m, vld_m, done_m, busy_m);
      check("basic_mem_rd_wave", rd_m,   32'h0000_00FF);
      check("basic_valid_wave",  vld_m,  32'h0000_03FC);
      check("basic_done_wave",   done_m, 32'h0000_0800);
      check("basic_busy_wave",   busy_m, 32'h0000_07FF);
      check("basic_strobes",     32'(rd_cnt - rd0), 32'd8);
      check("basic_words",       32'(got.size() - g0), 32'd8);
      check("basic_data_errs",   32'(data_errs(g0, 0, 8)), 32'd0);
      check("basic_done_count",  32'(done_cnt - d0), 32'd1);

      // Backpressure, len=16, stalled 20 cycles
      do_reset();
      rd0 = rd_cnt; g0 = got.size();
      bus.out_ready = 1'b0;
      bus.len       = LW'(16);
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (2) tick();
      snap = bus.out_data;
      repeat (17) tick();
      check("bp_stall_strobes", 32'(rd_cnt - rd0), 32'd4);
      check("bp_frozen_early",  32'(snap), 32'(word(0)));
      check("bp_frozen_late",   32'(bus.out_data), 32'(word(0)));
      check("bp_stall_valid",   32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      wait_done(100, "bp");
      check("bp_total_strobes", 32'(rd_cnt - rd0), 32'd16);
      check("bp_words",         32'(got.size() - g0), 32'd16);
      check("bp_data_errs",     32'(data_errs(g0, 0, 16)), 32'd0);

      // Random ready, len=511
      do_reset();
      rd0 = rd_cnt; g0 = got.size(); d0 = done_cnt;
      bus.len   = LW'(511);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 6000) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("rnd_done_seen", 32'(bus.done), 32'd1);
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check("rnd_strobes",    32'(rd_cnt - rd0), 32'd511);
      check("rnd_handshakes", 32'(got.size() - g0), 32'd511);
      check("rnd_data_errs",  32'(data_errs(g0, 0, 511)), 32'd0);
      check("rnd_fifo_max",   32'(max_cnt <= DEPTH), 32'd1);
      check("rnd_done_count", 32'(done_cnt - d0), 32'd1);

      // Zero length
      do_reset();
      rd0 = rd_cnt; d0 = done_cnt;
      bus.len   = '0;
      bus.start = 1'b1;
      record(4, rd_m, vld_m, done_m, busy_m);
      check("zero_mem_rd_wave", rd_m,   32'h0);
      check("zero_valid_wave",  vld_m,  32'h0);
      check("zero_done_wave",   done_m, 32'h1);
      check("zero_busy_wave",   busy_m, 32'h0);
      check("zero_done_count",  32'(done_cnt - d0), 32'd1);

      // Abort after three handshakes, then a len=2 burst
      do_reset();
      rd0 = rd_cnt; g0 = got.size(); d0 = done_cnt;
      bus.out_ready = 1'b1;
      bus.len       = LW'(10);
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (got.size() - g0 < 3 && n < 50) begin
         tick();
         n++;
      end
      bus.out_ready = 1'b0;
      bus.abort     = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_valid",   32'(bus.out_valid), 32'd0);
      check("abort_mem_rd",  32'(bus.mem_rd),    32'd0);
      check("abort_busy",    32'(bus.busy),      32'd0);
      check("abort_strobes", 32'(rd_cnt - rd0),  32'd6);
      repeat (5) tick();
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_words",   32'(got.size() - g0), 32'd3);
      g1 = got.size();
      bus.out_ready = 1'b1;
      bus.len       = LW'(2);
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(20, "abort_restart");
      check("abort_restart_words", 32'(got.size() - g1), 32'd2);
      check("abort_restart_data",  32'(data_errs(g1, 6, 2)), 32'd0);

      // Asynchronous reset mid-burst
      do_reset();
      bus.out_ready = 1'b0;
      bus.len       = LW'(16);
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      check("pre_reset_busy",  32'(bus.busy),      32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid",  32'(bus.out_valid), 32'd0);
      check("async_rst_mem_rd", 32'(bus.mem_rd),    32'd0);
      check("async_rst_busy",   32'(bus.busy),      32'd0);
      check("async_rst_data",   32'(bus.out_data),  32'd0);
      check("async_rst_done",   32'(bus.done),      32'd0);
      tick();
      reset = 1'b0;

      // Start during RUN is ignored
      rd0 = rd_cnt; g0 = got.size();
      bus.len   = LW'(5);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.len   = LW'(3);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("ign_busy", 32'(bus.busy), 32'd1);
      bus.out_ready = 1'b1;
      wait_done(50, "ign");
      check("ign_strobes",   32'(rd_cnt - rd0), 32'd5);
      check("ign_words",     32'(got.size() - g0), 32'd5);
      check("ign_data_errs", 32'(data_errs(g0, 0, 5)), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
